seq_div: RTL and testbench



---
 rtl/seq_div.sv | 100 ++++++++++
 tb/tb_seq_div.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, one quotient bit per clock; define SEQ_DIV_SIGNED_EN for two's-complement operands
module seq_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N:0]    prem;
  logic [N-1:0]  qreg, dvs;
  logic [N:0]    shifted, diff, new_prem;
  logic [N-1:0]  new_q, a_mag, b_mag, q_out, r_out;
  logic          ge;
  assign busy = state == RUN;
  assign done = state == DONE;
  // one restoring step: shift in the next dividend bit and keep the trial difference if it did not borrow
  always_comb begin
    shifted  = {prem[N-1:0], qreg[N-1]};
    diff     = shifted - {1'b0, dvs};
    ge       = ~diff[N];
    new_prem = ge ? diff : shifted;
    new_q    = {qreg[N-2:0], ge};
  end
`ifdef SEQ_DIV_SIGNED_EN
  logic sign_q, sign_r;
  // divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    a_mag = dividend[N-1] ? -dividend : dividend;
    b_mag = divisor[N-1] ? -divisor : divisor;
    q_out = sign_q ? -new_q : new_q;
    r_out = sign_r ? -new_prem[N-1:0] : new_prem[N-1:0];
  end
  // result signs are fixed at capture since the operand inputs may change afterwards
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (state == IDLE && start) begin
      sign_q <= dividend[N-1] ^ divisor[N-1];
      sign_r <= dividend[N-1];
    end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_out = new_q;
  assign r_out = new_prem[N-1:0];
`endif
  // control FSM and datapath; results load only when entering DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      prem        <= '0;
      qreg        <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          qreg <= a_mag;
          dvs  <= b_mag;
          cnt  <= CW'(N);
          prem <= '0;
          if (divisor == '0) begin
            state       <= DONE;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else state <= RUN;
        end
        RUN: begin
          prem <= new_prem;
          qreg <= new_q;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            quotient    <= q_out;
            remainder   <= r_out;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div with directed vectors (N=4)
module tb_seq_div;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  int checks = 0;
  int errors = 0;
  logic [3:0] last_q = '0, last_r = '0;
  logic last_z = 1'b0;
  typedef struct packed {logic [3:0] q; logic [3:0] r; logic z;} exp_t;
  exp_t sb[$];
  exp_t e;
`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [3:0] Q13 = 4'b1111, R13 = 4'b0000;
  localparam logic [3:0] Q9 = 4'b1101, R9 = 4'b1111;
  localparam logic [3:0] Q14 = 4'b0000, R14 = 4'b1110;
`else
  localparam logic [3:0] Q13 = 4'b0100, R13 = 4'b0001;
  localparam logic [3:0] Q9 = 4'b0100, R9 = 4'b0001;
  localparam logic [3:0] Q14 = 4'b0100, R14 = 4'b0010;
`endif

  seq_div #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.z));
      end
    end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                        input logic [3:0] er, input logic ez, input bit repulse);
    int cyc, nbusy;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back('{eq, er, ez});
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = ~b;
    cyc = 1; nbusy = 0;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      chk("hold_quotient", int'(quotient), int'(last_q));
      chk("hold_remainder", int'(remainder), int'(last_r));
      start = repulse && cyc == 2;
      if (start) begin dividend = 4'hf; divisor = 4'hf; end
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", cyc, ez ? 1 : 5);
    chk("busy_cycles", nbusy, ez ? 0 : 4);
    chk("busy_in_done", int'(busy), 0);
    last_q = eq; last_r = er; last_z = ez;
    if (repulse) begin
      start = 1'b1; dividend = 4'hf; divisor = 4'hf;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", int'(done), 0);
      chk("start_in_done_ignored", int'(busy), 0);
      @(negedge clk);
      chk("still_idle", int'(busy), 0);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd13, 4'd3, Q13, R13, 1'b0, 1'b0);
    run_op(4'd15, 4'd1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    run_op(4'd3, 4'd5, 4'b0000, 4'b0011, 1'b0, 1'b0);
    run_op(4'd7, 4'd0, 4'b1111, 4'b0111, 1'b1, 1'b0);
    run_op(4'd6, 4'd2, 4'b0011, 4'b0000, 1'b0, 1'b0);
    run_op(4'd9, 4'd2, Q9, R9, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    last_q = '0; last_r = '0; last_z = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done | busy), 0);
    end
    run_op(4'd14, 4'd3, Q14, R14, 1'b0, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
    run_op(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0);
    run_op(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0);
    run_op(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b0);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_dbz_hold", int'(div_by_zero), int'(last_z));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
